// File: rtl/gate_response_checker.sv
// Response checker for 2-input gate blocks: sweeps all A/B pairs, compares the six
// gate outputs against golden values and accumulates mismatch statistics.
module gate_response_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [5:0]       y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [5:0]       fail_vec,
  output logic [1:0]       first_fail_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);
  localparam logic [PW-1:0] PASS_ONE    = PW'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // Expected outputs in y_in bit order: {xor, xnor, or, nor, nand, and}
  function automatic logic [5:0] golden(input logic a, input logic b);
    golden = {a ^ b, ~(a ^ b), a | b, ~(a | b), ~(a & b), a & b};
  endfunction

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    popcount6 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      popcount6 = popcount6 + {2'b00, v[i]};
    end
  endfunction

  logic [2:0]         state;
  logic [1:0]         index;
  logic [PW-1:0]      pass_cnt;
  logic [SW-1:0]      settle_cnt;
  logic [5:0]         mm;
  logic [ERR_W+2:0]   err_sum;
  logic [ERR_W-1:0]   err_next;

  // Mismatch vector and saturating error total for the current sample
  always_comb begin
    mm       = y_in ^ golden(a_out, b_out);
    err_sum  = {3'b000, err_count} + {{ERR_W{1'b0}}, popcount6(mm)};
    if (err_sum > {3'b000, ERR_MAX}) begin
      err_next = ERR_MAX;
    end else begin
      err_next = err_sum[ERR_W-1:0];
    end
  end

  // Sweep sequencer and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      index          <= 2'd0;
      pass_cnt       <= '0;
      settle_cnt     <= '0;
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_vec       <= 6'd0;
      first_fail_idx <= 2'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            index          <= 2'd0;
            pass_cnt       <= '0;
            err_count      <= '0;
            fail_vec       <= 6'd0;
            first_fail_idx <= 2'd0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= S_DRIVE;
          end else begin
            state <= state;
          end
        end
        S_DRIVE: begin
          a_out      <= index[1];
          b_out      <= index[0];
          settle_cnt <= '0;
          state      <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_ONE;
          end
        end
        S_SAMPLE: begin
          err_count <= err_next;
          fail_vec  <= fail_vec | mm;
          // An empty fail_vec means no mismatch has been seen yet this run
          if ((mm != 6'd0) && (fail_vec == 6'd0)) begin
            first_fail_idx <= {a_out, b_out};
          end else begin
            first_fail_idx <= first_fail_idx;
          end
          if (index != 2'd3) begin
            index <= index + 2'd1;
            state <= S_DRIVE;
          end else if (pass_cnt != PASS_LAST) begin
            index    <= 2'd0;
            pass_cnt <= pass_cnt + PASS_ONE;
            state    <= S_DRIVE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: a behavioural gate model with injectable
// faults feeds two checker instances; expected results are queued at each start.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start2;
  logic [1:0] fmode;
  logic       sel;

  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [5:0] fv1, y1;
  logic [1:0] ffi1;

  logic       a2, b2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [5:0] fv2, y2;
  logic [1:0] ffi2;

  gate_response_checker dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fv1), .first_fail_idx(ffi1)
  );

  gate_response_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_vec(fv2), .first_fail_idx(ffi2)
  );

  // Truth-table gate model; mode 1 = nand stuck-at-0, 2 = and/or swapped, 3 = all inverted
  function automatic logic [5:0] gate_model(input logic a, input logic b, input logic [1:0] m);
    logic [5:0] g;
    case ({a, b})
      2'b00:   g = 6'b010110;
      2'b01:   g = 6'b101010;
      2'b10:   g = 6'b101010;
      default: g = 6'b011001;
    endcase
    case (m)
      2'd1:    g[1] = 1'b0;
      2'd2:    g = {g[5], g[4], g[0], g[2], g[1], g[3]};
      2'd3:    g = ~g;
      default: g = g;
    endcase
    return g;
  endfunction

  always_comb y1 = gate_model(a1, b1, fmode);
  always_comb y2 = gate_model(a2, b2, fmode);

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [5:0] o_fv;
  logic [1:0] o_ffi;
  always_comb begin
    o_a    = sel ? a2 : a1;
    o_b    = sel ? b2 : b1;
    o_busy = sel ? busy2 : busy1;
    o_done = sel ? done2 : done1;
    o_pass = sel ? pass2 : pass1;
    o_err  = sel ? {2'b00, err2} : err1;
    o_fv   = sel ? fv2 : fv1;
    o_ffi  = sel ? ffi2 : ffi1;
  end

  typedef struct {
    logic [3:0] err;
    logic [5:0] fv;
    logic [1:0] ffi;
    logic       pass;
    int         cycles;
    int         passes;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] vq[$];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete run on the selected instance, scored against the head of sb
  task automatic run(input logic s, input logic [1:0] m, input logic mid_start);
    exp_t e;
    int   cyc;
    e     = sb.pop_front();
    sel   = s;
    fmode = m;
    for (int p = 0; p < e.passes; p++)
      for (int i = 0; i < 4; i++) vq.push_back(2'(i));
    @(negedge clk);
    if (s) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_done", 32'(o_done), 32'd0);
    chk("start_err_clr", 32'(o_err), 32'd0);
    chk("start_fv_clr", 32'(o_fv), 32'd0);
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      cyc = c;
      if (mid_start && c == 5) start1 = 1'b1;
      if (mid_start && c == 6) start1 = 1'b0;
      if ((c % 3 == 1) && (vq.size() != 0)) chk("vector_ab", 32'({o_a, o_b}), 32'(vq.pop_front()));
      if (o_done) break;
    end
    chk("done_cycle", 32'(cyc), 32'(e.cycles));
    chk("vectors_left", 32'(vq.size()), 32'd0);
    vq.delete();
    chk("end_busy", 32'(o_busy), 32'd0);
    chk("err_count", 32'(o_err), 32'(e.err));
    chk("fail_vec", 32'(o_fv), 32'(e.fv));
    chk("pass", 32'(o_pass), 32'(e.pass));
    if (e.err != 4'd0) chk("first_fail_idx", 32'(o_ffi), 32'(e.ffi));
    @(posedge clk); #1;
    chk("done_hold", 32'(o_done), 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    fmode  = 2'd0;
    sel    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs1", 32'({a1, b1, busy1, done1, pass1, err1, fv1, ffi1}), 32'd0);
    chk("reset_outs2", 32'({a2, b2, busy2, done2, pass2, err2, fv2, ffi2}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Golden gate, then two single-fault cases
    sb.push_back('{err: 4'd0, fv: 6'h00, ffi: 2'b00, pass: 1'b1, cycles: 12, passes: 1});
    run(1'b0, 2'd0, 1'b0);
    sb.push_back('{err: 4'd3, fv: 6'b000010, ffi: 2'b00, pass: 1'b0, cycles: 12, passes: 1});
    run(1'b0, 2'd1, 1'b0);
    sb.push_back('{err: 4'd4, fv: 6'b001001, ffi: 2'b01, pass: 1'b0, cycles: 12, passes: 1});
    run(1'b0, 2'd2, 1'b0);

    // Restart from DONE with errors pending, plus a start pulse mid-run
    sb.push_back('{err: 4'd0, fv: 6'h00, ffi: 2'b00, pass: 1'b1, cycles: 12, passes: 1});
    run(1'b0, 2'd0, 1'b1);

    // Reset during the third vector's settle cycle
    sel   = 1'b0;
    fmode = 2'd1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_reset_ab", 32'({a1, b1}), 32'd2);
    chk("pre_reset_err", 32'(err1), 32'd2);
    rst = 1'b1;
    #1;
    chk("abort_outs", 32'({a1, b1, busy1, done1, pass1, err1, fv1, ffi1}), 32'd0);
    @(posedge clk); #1;
    chk("abort_idle", 32'({busy1, done1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{err: 4'd0, fv: 6'h00, ffi: 2'b00, pass: 1'b1, cycles: 12, passes: 1});
    run(1'b0, 2'd0, 1'b0);

    // Narrow counter, two passes, every output inverted
    sb.push_back('{err: 4'd3, fv: 6'h3F, ffi: 2'b00, pass: 1'b0, cycles: 24, passes: 2});
    run(1'b1, 2'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
